led_shift_ctrl: RTL and testbench
=================================

LED_SHIFT_CTRL -- requirements
Module: led_shift_ctrl

Interface
REQ-001 The block SHALL have parameter CLKS_PER_STEP, default 10, giving the clock cycles between consecutive shift pulses and between blink toggles (legal range 2..2^24).
REQ-002 The block SHALL have parameter BLINK_TOGGLES, default 6, giving the number of off_o toggles in the blink phase (legal range 2..255, even).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port go_i, input, 1 bit: single-cycle start/acknowledge request.
REQ-006 The block SHALL have port stop_i, input, 1 bit: single-cycle player stop request.
REQ-007 The block SHALL have port load_req_i, input, 1 bit: single-cycle request to load the switch pattern.
REQ-008 The block SHALL have port leds_full_i, input, 1 bit: high when the downstream LED shifter's output is all ones.
REQ-009 The block SHALL have port shift_o, output, 1 bit: one-cycle shift command to the LED shifter.
REQ-010 The block SHALL have port load_o, output, 1 bit: one-cycle load command to the LED shifter.
REQ-011 The block SHALL have port off_o, output, 1 bit: LED blanking command to the LED shifter.
REQ-012 The block SHALL have port state_o, output, 2 bits: current state, IDLE=0, RUN=1, STOPPED=2, BLINK=3.

Function
REQ-013 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-014 In IDLE with load_req_i=1, load_o SHALL be 1 for exactly the following cycle, and the state SHALL remain IDLE.
REQ-015 In IDLE with go_i=1 and load_req_i=0, the next state SHALL be RUN and the step counter SHALL clear to 0.
REQ-016 In IDLE, when load_req_i and go_i are both 1, the load SHALL take priority: load_o pulses and go_i is ignored.
REQ-017 In RUN, the step counter SHALL increment each cycle from 0 to CLKS_PER_STEP-1 and then wrap to 0.
REQ-018 In RUN, when the counter equals CLKS_PER_STEP-1, shift_o SHALL be 1 for exactly the following cycle.
REQ-019 The first shift_o pulse SHALL occur CLKS_PER_STEP cycles after the state_o=RUN cycle; subsequent pulses SHALL be exactly CLKS_PER_STEP cycles apart.
REQ-020 In RUN with stop_i=1, the next state SHALL be STOPPED and no shift_o pulse SHALL be produced for that cycle, even at terminal count.
REQ-021 In RUN with leds_full_i=1 and stop_i=0, the next state SHALL be BLINK, the counter SHALL clear, and any terminal-count shift in that cycle SHALL be suppressed.
REQ-022 In RUN, go_i and load_req_i SHALL be ignored.
REQ-023 In STOPPED, shift_o and load_o SHALL be 0 and off_o SHALL be 0.
REQ-024 In STOPPED, go_i=1 SHALL return the state to IDLE; all other inputs SHALL be ignored.
REQ-025 On entry to BLINK, off_o SHALL be 0.
REQ-026 In BLINK, off_o SHALL toggle each time the counter reaches CLKS_PER_STEP-1, with the counter wrapping to 0.
REQ-027 After BLINK_TOGGLES toggles, the state SHALL return to IDLE with off_o=0.
REQ-028 In BLINK, the toggle count SHALL be held in an 8-bit counter that clears on BLINK entry.
REQ-029 In BLINK, go_i, stop_i, load_req_i and leds_full_i SHALL be ignored; shift_o and load_o SHALL be 0.
REQ-030 Outside BLINK, off_o SHALL be 0.
REQ-031 The step counter width SHALL be $clog2(CLKS_PER_STEP) bits and it SHALL never exceed CLKS_PER_STEP-1.

Reset
REQ-032 While rst_ni=0 at a rising edge, the state SHALL become IDLE; shift_o, load_o and off_o SHALL become 0; and both counters SHALL clear to 0.
REQ-033 Reset asserted mid-RUN or mid-BLINK SHALL abort the operation with no further shift_o or off_o activity after the reset edge.
REQ-034 The first cycle after reset release SHALL accept go_i or load_req_i normally.

Verification (CLKS_PER_STEP=4, BLINK_TOGGLES=4)
REQ-035 Reset, then load_req_i pulse in IDLE -> load_o=1 exactly one cycle later; state_o stays 0.
REQ-036 go_i pulse, then hold for 13 cycles -> state_o=1; shift_o pulses at cycles 4, 8 and 12 after RUN entry, each one cycle wide.
REQ-037 stop_i asserted on a terminal-count cycle -> state_o=2 and no shift_o pulse; a later go_i -> state_o=0.
REQ-038 leds_full_i=1 in RUN -> state_o=3; off_o pattern 0,1,0,1,0 with each level held 4 cycles; then state_o=0 and off_o=0.
REQ-039 load_req_i and go_i together in IDLE -> load_o pulse, state_o stays 0; stop_i and leds_full_i together in RUN -> state_o=2.
REQ-040 rst_ni=0 for one cycle mid-BLINK while off_o=1 -> next cycle off_o=0, state_o=0, no shift_o.

Source files
------------

// File: rtl/led_shift_ctrl.sv
// Purpose: sequencing controller for an LED shifter (load / timed shift / blink-on-full).
// Latency: all outputs are registered; a command appears one cycle after the deciding input.
// Backpressure: none; single-cycle request inputs, outputs are single-cycle pulses or levels.
module led_shift_ctrl #(
  parameter int CLKS_PER_STEP = 10,
  parameter int BLINK_TOGGLES = 6
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       go_i,
  input  logic       stop_i,
  input  logic       load_req_i,
  input  logic       leds_full_i,
  output logic       shift_o,
  output logic       load_o,
  output logic       off_o,
  output logic [1:0] state_o
);

  localparam int CNT_W = (CLKS_PER_STEP > 1) ? $clog2(CLKS_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] TC       = CNT_W'(CLKS_PER_STEP - 1);
  localparam logic [7:0]       TOG_LAST = 8'(BLINK_TOGGLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_STOPPED = 2'd2,
    S_BLINK   = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]       r_tog, w_tog_nxt;
  logic             r_shift, r_load, r_off;
  logic             w_shift_nxt, w_load_nxt, w_off_nxt;
  logic             w_tc, w_tog_last;

  assign w_tc       = (r_cnt == TC);
  assign w_tog_last = (r_tog == TOG_LAST);

  // State, counters and output registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_tog   <= '0;
      r_shift <= 1'b0;
      r_load  <= 1'b0;
      r_off   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tog   <= w_tog_nxt;
      r_shift <= w_shift_nxt;
      r_load  <= w_load_nxt;
      r_off   <= w_off_nxt;
    end
  end

  // Next-state decision; load beats go in IDLE, stop beats leds_full in RUN
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (!load_req_i && go_i) w_state_nxt = S_RUN;
      S_RUN: begin
        if (stop_i)           w_state_nxt = S_STOPPED;
        else if (leds_full_i) w_state_nxt = S_BLINK;
      end
      S_STOPPED: if (go_i) w_state_nxt = S_IDLE;
      S_BLINK:   if (w_tc && w_tog_last) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Step and toggle counters; both sit at zero whenever they are not in use
  always_comb begin
    w_cnt_nxt = '0;
    w_tog_nxt = '0;
    case (r_state)
      S_RUN: begin
        if (!stop_i && !leds_full_i)
          w_cnt_nxt = w_tc ? '0 : r_cnt + CNT_W'(1);
      end
      S_BLINK: begin
        w_cnt_nxt = w_tc ? '0 : r_cnt + CNT_W'(1);
        if (w_tc) w_tog_nxt = w_tog_last ? 8'd0 : r_tog + 8'd1;
        else      w_tog_nxt = r_tog;
      end
      default: ;
    endcase
  end

  // Next values of the registered commands; the last blink toggle lands on off=0
  always_comb begin
    w_shift_nxt = (r_state == S_RUN) && w_tc && !stop_i && !leds_full_i;
    w_load_nxt  = (r_state == S_IDLE) && load_req_i;
    w_off_nxt   = 1'b0;
    if (r_state == S_BLINK) begin
      if (w_tc) w_off_nxt = w_tog_last ? 1'b0 : ~r_off;
      else      w_off_nxt = r_off;
    end
  end

  assign shift_o = r_shift;
  assign load_o  = r_load;
  assign off_o   = r_off;
  assign state_o = r_state;

endmodule

// File: tb/tb_led_shift_ctrl.sv
// Directed vector bench for led_shift_ctrl with CLKS_PER_STEP=4, BLINK_TOGGLES=4.
// Each vector holds the inputs for one cycle and the outputs expected after that edge.
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
module tb_led_shift_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, go, stop, load_req, full;
  logic       shift, load, off;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  led_shift_ctrl #(.CLKS_PER_STEP(4), .BLINK_TOGGLES(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .go_i(go), .stop_i(stop),
    .load_req_i(load_req), .leds_full_i(full),
    .shift_o(shift), .load_o(load), .off_o(off), .state_o(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n, go, stop, load, full;
    logic [1:0] e_state;
    logic       e_shift, e_load, e_off;
    string      tag;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic r, input logic g, input logic s, input logic l, input logic f,
                   input logic [1:0] es, input logic esh, input logic el, input logic eo,
                   input string tag);
    vec_t x;
    x.rst_n = r; x.go = g; x.stop = s; x.load = l; x.full = f;
    x.e_state = es; x.e_shift = esh; x.e_load = el; x.e_off = eo; x.tag = tag;
    vecs.push_back(x);
  endtask

  task automatic chk(input string what, input int idx, input string tag,
                     input logic [1:0] got, input logic [1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s %s vec%0d: got=%0d exp=%0d", tag, what, idx, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; go = 1'b0; stop = 1'b0; load_req = 1'b0; full = 1'b0;

    // reset state
    v(0,0,0,0,0, 2'd0,0,0,0, "reset");
    v(0,0,0,0,0, 2'd0,0,0,0, "reset");
    // load in IDLE: one-cycle pulse, state stays IDLE
    v(1,0,0,1,0, 2'd0,0,1,0, "load");
    v(1,0,0,0,0, 2'd0,0,0,0, "load_end");
    // go: RUN cycle 0, then shift pulses at cycles 4, 8, 12
    v(1,1,0,0,0, 2'd1,0,0,0, "go");
    for (int k = 1; k <= 15; k++)
      v(1,0,0,0,0, 2'd1, (k % 4 == 0), 0,0, "run");
    // cycle 15 is terminal count: stop suppresses the shift
    v(1,0,1,0,0, 2'd2,0,0,0, "stop_tc");
    v(1,0,1,1,1, 2'd2,0,0,0, "stopped_ign");
    v(1,0,0,0,0, 2'd2,0,0,0, "stopped");
    v(1,1,0,0,0, 2'd0,0,0,0, "stopped_go");
    // load and go together: load wins
    v(1,1,0,1,0, 2'd0,0,1,0, "load_go");
    v(1,0,0,0,0, 2'd0,0,0,0, "load_go_end");
    // stop and leds_full together in RUN: stop wins
    v(1,1,0,0,0, 2'd1,0,0,0, "go2");
    v(1,0,1,0,1, 2'd2,0,0,0, "stop_full");
    v(1,1,0,0,0, 2'd0,0,0,0, "to_idle");
    // leds_full on a terminal-count cycle: BLINK, shift suppressed
    v(1,1,0,0,0, 2'd1,0,0,0, "go3");
    for (int k = 1; k <= 3; k++)
      v(1,0,0,0,0, 2'd1,0,0,0, "run3");
    v(1,0,0,0,1, 2'd3,0,0,0, "full_tc");
    for (int b = 1; b <= 15; b++)
      v(1, (b == 2), (b == 5), (b == 9), 1, 2'd3, 0, 0, ((b / 4) % 2 == 1), "blink");
    v(1,0,0,0,0, 2'd0,0,0,0, "blink_done");
    v(1,0,0,0,0, 2'd0,0,0,0, "idle_after");
    // reset mid-BLINK while off=1
    v(1,1,0,0,0, 2'd1,0,0,0, "go4");
    v(1,0,0,0,1, 2'd3,0,0,0, "full4");
    for (int b = 1; b <= 5; b++)
      v(1,0,0,0,0, 2'd3,0,0, (b >= 4), "blink4");
    v(0,0,0,0,0, 2'd0,0,0,0, "rst_blink");
    // go accepted on the first cycle after reset release
    v(1,1,0,0,0, 2'd1,0,0,0, "go_after_rst");
    for (int k = 1; k <= 3; k++)
      v(1,0,0,0,0, 2'd1,0,0,0, "run5");
    // reset at terminal count: the pending shift never appears
    v(0,0,0,0,0, 2'd0,0,0,0, "rst_run");
    for (int k = 0; k < 6; k++)
      v(1,0,0,0,0, 2'd0,0,0,0, "quiet");

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n    = vecs[i].rst_n;
      go       = vecs[i].go;
      stop     = vecs[i].stop;
      load_req = vecs[i].load;
      full     = vecs[i].full;
      @(posedge clk);
      #1;
      chk("state", i, vecs[i].tag, state,        vecs[i].e_state);
      chk("shift", i, vecs[i].tag, {1'b0, shift}, {1'b0, vecs[i].e_shift});
      chk("load",  i, vecs[i].tag, {1'b0, load},  {1'b0, vecs[i].e_load});
      chk("off",   i, vecs[i].tag, {1'b0, off},   {1'b0, vecs[i].e_off});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
